// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with optional parity feeding a small receive FIFO.
// Errored frames are dropped and flagged with one-cycle pulses; a full FIFO drops new bytes.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               ser_rx,
  input  logic [15:0]                        clk_div,
  output logic [7:0]                         rx_data,
  output logic                               rx_valid,
  input  logic                               rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync2_q;
  logic [15:0]            div_cnt_q, div_cnt_d, div_lat_q, div_lat_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bad_q, par_bad_d;
  logic                   frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic                   rx, tick, sample_half, sample_full, push, pop, full, wr_en;

  assign rx          = sync2_q;
  assign tick        = (div_cnt_q == div_lat_q);
  assign sample_half = tick && (tick_cnt_q == TW'(OVERSAMPLE/2 - 1));
  assign sample_full = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

  // The divisor is latched at each wrap so a mid-frame change lands on a tick boundary.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    div_lat_d = div_lat_q;
    if (state_q == S_IDLE || tick) begin
      div_cnt_d = '0;
      div_lat_d = clk_div;
    end
  end

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        par_bad_d  = 1'b0;
        if (!rx) state_d = S_START;
      end
      S_START: begin
        if (sample_half) begin
          tick_cnt_d = '0;
          state_d    = rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          shift_d    = {rx, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          par_bad_d  = (PARITY == 2) ? ~(^shift_q ^ rx) : (^shift_q ^ rx);
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_full) begin
          tick_cnt_d = '0;
          if (!rx) begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end else if (par_bad_q) begin
            parity_err_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            push    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop frees a slot in the same cycle, so a push onto a full FIFO with a pop is accepted.
  always_comb begin
    pop       = (level_q != '0) && rx_ready;
    full      = (level_q == LW'(FIFO_DEPTH));
    wr_en     = push && (!full || pop);
    overrun_d = push && full && !pop;
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d   = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (!wr_en && pop) level_d = level_q - 1'b1;
  end

  always_comb begin
    rx_data = '0;
    if (level_q != '0) rx_data[DATA_BITS-1:0] = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      div_lat_q    <= '0;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      sync1_q      <= ser_rx;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_lat_q    <= div_lat_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  assign rx_valid   = (level_q != '0);
  assign rx_level   = level_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
endmodule
